// File: rtl/trn_tx_pkg.sv
// trn_tx_pkg: shared definitions for the TRN transmit arbiter.
// TLP class codes, arbiter state encoding and the remainder-width helper.
package trn_tx_pkg;

    localparam logic [1:0] CLS_NP  = 2'd0;
    localparam logic [1:0] CLS_P   = 2'd1;
    localparam logic [1:0] CLS_CPL = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One trn_trem_n bit per data byte.
    function automatic int calc_remw(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/trn_rr_pick.sv
// trn_rr_pick: combinational round-robin picker.
// Searches the request vector starting one past last_grant and wrapping
// modulo NCH; returns a one-hot grant, its index and an any-grant flag.
module trn_rr_pick #(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last_grant,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  gnt_idx,
    output logic           gnt_any
);

    // First requester after last_grant in circular order wins.
    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            c = (int'(last_grant) + k) % NCH;
            if (!gnt_any && req[c]) begin
                gnt_any  = 1'b1;
                gnt[c]   = 1'b1;
                gnt_idx  = IW'(c);
            end
        end
    end

endmodule

// File: rtl/trn_tx_arbiter.sv
// trn_tx_arbiter: packet-atomic round-robin merge of NCH producer TLP
// streams onto the endpoint TRN transmit interface.
// Optional build macro TRN_TX_ARB_STATS_EN adds per-channel packet and
// discontinue counters (pkt_cnt, dsc_cnt).
module trn_tx_arbiter
    import trn_tx_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DW   = 64,
    parameter int REMW = calc_remw(DW)
) (
    input  logic                trn_clk,
    input  logic                trn_reset_n,
    input  logic [NCH*DW-1:0]   ch_td,
    input  logic [NCH*REMW-1:0] ch_trem_n,
    input  logic [NCH-1:0]      ch_tsof_n,
    input  logic [NCH-1:0]      ch_teof_n,
    input  logic [NCH-1:0]      ch_tsrc_rdy_n,
    input  logic [NCH*2-1:0]    ch_type,
    output logic [NCH-1:0]      ch_tdst_rdy_n,
    output logic [DW-1:0]       trn_td,
    output logic [REMW-1:0]     trn_trem_n,
    output logic                trn_tsof_n,
    output logic                trn_teof_n,
    output logic                trn_tsrc_rdy_n,
    output logic                trn_tsrc_dsc_n,
    input  logic                trn_tdst_rdy_n,
    input  logic                trn_tdst_dsc_n,
    input  logic [3:0]          trn_tbuf_av,
    input  logic                trn_lnk_up_n
`ifdef TRN_TX_ARB_STATS_EN
    ,
    output logic [NCH*16-1:0]   pkt_cnt,
    output logic [NCH*8-1:0]    dsc_cnt
`endif
);

    localparam int IW = $clog2(NCH);

    state_t          state, state_n;
    logic [IW-1:0]   gnt_idx, gnt_idx_n;
    logic [IW-1:0]   last_grant, last_grant_n;
    logic            eof_acc, eof_acc_n;

    logic [NCH-1:0]  req, pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic            vld_p1, sof_p1, eof_p1;
    logic [DW-1:0]   td_p1;
    logic [REMW-1:0] trem_p1;

    logic            load, clr, dsc_now;
    logic [IW-1:0]   load_idx;
    logic [NCH-1:0]  rdy_n;

    logic            lnk_up, core_rdy, core_dsc, drains;

    assign lnk_up   = !trn_lnk_up_n;
    assign core_rdy = !trn_tdst_rdy_n;
    assign core_dsc = !trn_tdst_dsc_n;
    assign drains   = vld_p1 && core_rdy;

    // A channel may start a packet only with sof, buffer credit for its class and link up.
    always_comb begin
        req = '0;
        for (int i = 0; i < NCH; i++)
            req[i] = !ch_tsrc_rdy_n[i] && !ch_tsof_n[i] &&
                     trn_tbuf_av[ch_type[i*2 +: 2]] && lnk_up;
    end

    trn_rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (pick_oh),
        .gnt_idx    (pick_idx),
        .gnt_any    (pick_any)
    );

    // Next-state, channel handshake and output-register load decisions.
    always_comb begin
        state_n      = state;
        gnt_idx_n    = gnt_idx;
        last_grant_n = last_grant;
        eof_acc_n    = eof_acc;
        rdy_n        = '1;
        load         = 1'b0;
        load_idx     = gnt_idx;
        clr          = 1'b0;
        dsc_now      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_idx_n = pick_idx;
                    eof_acc_n = 1'b0;
                    state_n   = XFER;
                end
            end
            XFER: begin
                if (!lnk_up || core_dsc) begin
                    // Abort: drop the held beat; finish consuming the packet if needed.
                    clr     = 1'b1;
                    dsc_now = !lnk_up;
                    state_n = eof_acc ? IDLE : DRAIN;
                end else if (eof_acc) begin
                    // Eof waits in the register; hand off to the next packet as it leaves.
                    if (drains) begin
                        if (pick_any) begin
                            rdy_n     = ~pick_oh;
                            load      = 1'b1;
                            load_idx  = pick_idx;
                            gnt_idx_n = pick_idx;
                            eof_acc_n = !ch_teof_n[pick_idx];
                            if (!ch_teof_n[pick_idx])
                                last_grant_n = pick_idx;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end else if (!vld_p1 || core_rdy) begin
                    rdy_n[gnt_idx] = 1'b0;
                    if (!ch_tsrc_rdy_n[gnt_idx]) begin
                        load = 1'b1;
                        if (!ch_teof_n[gnt_idx]) begin
                            eof_acc_n    = 1'b1;
                            last_grant_n = gnt_idx;
                        end
                    end
                end
            end
            DRAIN: begin
                rdy_n[gnt_idx] = 1'b0;
                if (!ch_tsrc_rdy_n[gnt_idx] && !ch_teof_n[gnt_idx]) begin
                    state_n      = IDLE;
                    last_grant_n = gnt_idx;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state: FSM, current grant, round-robin pointer, eof-seen flag.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state      <= IDLE;
            gnt_idx    <= '0;
            last_grant <= IW'(NCH - 1);
            eof_acc    <= 1'b0;
        end else begin
            state      <= state_n;
            gnt_idx    <= gnt_idx_n;
            last_grant <= last_grant_n;
            eof_acc    <= eof_acc_n;
        end
    end

    // ---- stage p1: single output register toward the core ----
    // Load an accepted beat, otherwise empty the register when it drains or aborts.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            vld_p1  <= 1'b0;
            sof_p1  <= 1'b0;
            eof_p1  <= 1'b0;
            td_p1   <= '0;
            trem_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            sof_p1  <= !ch_tsof_n[load_idx];
            eof_p1  <= !ch_teof_n[load_idx];
            td_p1   <= ch_td[int'(load_idx)*DW +: DW];
            trem_p1 <= ch_trem_n[int'(load_idx)*REMW +: REMW];
        end else if (clr || drains) begin
            vld_p1  <= 1'b0;
            sof_p1  <= 1'b0;
            eof_p1  <= 1'b0;
        end
    end

    assign ch_tdst_rdy_n  = rdy_n;
    assign trn_td         = td_p1;
    assign trn_trem_n     = trem_p1;
    assign trn_tsof_n     = !sof_p1;
    assign trn_teof_n     = !eof_p1;
    assign trn_tsrc_rdy_n = !vld_p1;
    assign trn_tsrc_dsc_n = !dsc_now;

`ifdef TRN_TX_ARB_STATS_EN
    // Per-channel completed-packet (wrapping) and discontinue (saturating) counters.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            pkt_cnt <= '0;
            dsc_cnt <= '0;
        end else if (state == XFER) begin
            if (lnk_up && !core_dsc && drains && eof_p1)
                pkt_cnt[int'(gnt_idx)*16 +: 16] <= pkt_cnt[int'(gnt_idx)*16 +: 16] + 16'd1;
            if ((!lnk_up || core_dsc) && dsc_cnt[int'(gnt_idx)*8 +: 8] != 8'hFF)
                dsc_cnt[int'(gnt_idx)*8 +: 8] <= dsc_cnt[int'(gnt_idx)*8 +: 8] + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trn_tx_arbiter.sv
// tb_trn_tx_arbiter: directed bench for trn_tx_arbiter (NCH=4, DW=64).
module tb_trn_tx_arbiter;

    localparam int NCH  = 4;
    localparam int DW   = 64;
    localparam int REMW = 8;

    logic                trn_clk = 1'b0;
    logic                trn_reset_n;
    logic [NCH*DW-1:0]   ch_td;
    logic [NCH*REMW-1:0] ch_trem_n;
    logic [NCH-1:0]      ch_tsof_n, ch_teof_n, ch_tsrc_rdy_n, ch_tdst_rdy_n;
    logic [NCH*2-1:0]    ch_type;
    logic [DW-1:0]       trn_td;
    logic [REMW-1:0]     trn_trem_n;
    logic                trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic                trn_tdst_rdy_n, trn_tdst_dsc_n, trn_lnk_up_n;
    logic [3:0]          trn_tbuf_av;
`ifdef TRN_TX_ARB_STATS_EN
    logic [NCH*16-1:0]   pkt_cnt;
    logic [NCH*8-1:0]    dsc_cnt;
`endif

    trn_tx_arbiter #(.NCH(NCH), .DW(DW), .REMW(REMW)) dut (
        .trn_clk        (trn_clk),
        .trn_reset_n    (trn_reset_n),
        .ch_td          (ch_td),
        .ch_trem_n      (ch_trem_n),
        .ch_tsof_n      (ch_tsof_n),
        .ch_teof_n      (ch_teof_n),
        .ch_tsrc_rdy_n  (ch_tsrc_rdy_n),
        .ch_type        (ch_type),
        .ch_tdst_rdy_n  (ch_tdst_rdy_n),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
        .trn_tdst_rdy_n (trn_tdst_rdy_n),
        .trn_tdst_dsc_n (trn_tdst_dsc_n),
        .trn_tbuf_av    (trn_tbuf_av),
        .trn_lnk_up_n   (trn_lnk_up_n)
`ifdef TRN_TX_ARB_STATS_EN
        ,
        .pkt_cnt        (pkt_cnt),
        .dsc_cnt        (dsc_cnt)
`endif
    );

    always #5 trn_clk = ~trn_clk;

    // Producer model: one packet per channel, presented beat by beat.
    logic [63:0] pk_td [NCH][16];
    int          pk_len [NCH];
    int          pk_pos [NCH];
    logic [1:0]  pk_ty  [NCH];

    // Beats delivered to the core.
    logic [63:0] log_td [$];
    bit          log_sof[$];
    int          log_cyc[$];
    int          cyc;
    logic [NCH-1:0] last_rdy;

    int errors;
    int checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_pkt(input int ch, input logic [1:0] ty, input int n, input logic [63:0] base);
        pk_len[ch] = n;
        pk_pos[ch] = 0;
        pk_ty[ch]  = ty;
        for (int k = 0; k < n; k++)
            pk_td[ch][k] = base + 64'(k);
    endtask

    task automatic drive_ch();
        for (int i = 0; i < NCH; i++) begin
            if (pk_pos[i] < pk_len[i]) begin
                ch_tsrc_rdy_n[i]    = 1'b0;
                ch_td[i*DW +: DW]   = pk_td[i][pk_pos[i]];
                ch_tsof_n[i]        = (pk_pos[i] != 0);
                ch_teof_n[i]        = (pk_pos[i] != pk_len[i] - 1);
            end else begin
                ch_tsrc_rdy_n[i]    = 1'b1;
                ch_td[i*DW +: DW]   = '0;
                ch_tsof_n[i]        = 1'b1;
                ch_teof_n[i]        = 1'b1;
            end
            ch_type[i*2 +: 2] = pk_ty[i];
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, advance producers at posedge.
    task automatic tick();
        logic [NCH-1:0] acc;
        drive_ch();
        #1;
        last_rdy = ch_tdst_rdy_n;
        acc      = ~ch_tdst_rdy_n & ~ch_tsrc_rdy_n;
        if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
            log_td.push_back(trn_td);
            log_sof.push_back(!trn_tsof_n);
            log_cyc.push_back(cyc);
        end
        @(posedge trn_clk);
        for (int i = 0; i < NCH; i++)
            if (acc[i]) pk_pos[i]++;
        cyc++;
        @(negedge trn_clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_log();
        log_td.delete();
        log_sof.delete();
        log_cyc.delete();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        trn_reset_n    = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        trn_tdst_dsc_n = 1'b1;
        trn_lnk_up_n   = 1'b0;
        trn_tbuf_av    = 4'b0010;
        ch_trem_n      = '0;
        for (int i = 0; i < NCH; i++) begin
            pk_len[i] = 0;
            pk_pos[i] = 0;
            pk_ty[i]  = 2'd1;
        end
        drive_ch();
        @(negedge trn_clk);
        @(negedge trn_clk);

        // Reset values
        chk("rst_src_rdy", trn_tsrc_rdy_n, 1);
        chk("rst_td", trn_td, 0);
        chk("rst_ch_rdy", ch_tdst_rdy_n, 4'hF);
        chk("rst_sof_eof", {trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n}, 3'b111);
        trn_reset_n = 1'b1;

        // Two P packets on ch0 and ch2, back to back
        load_pkt(0, 2'd1, 3, 64'h100);
        load_pkt(2, 2'd1, 3, 64'h200);
        clear_log();
        ticks(10);
        chk("t1_count", log_td.size(), 6);
        chk("t1_first", log_td[0], 64'h100);
        chk("t1_ch0_last", log_td[2], 64'h102);
        chk("t1_ch2_first", log_td[3], 64'h200);
        chk("t1_ch2_sof", log_sof[3], 1);
        chk("t1_ch2_last", log_td[5], 64'h202);
        chk("t1_no_bubble", log_cyc[3] - log_cyc[2], 1);
        chk("t1_last_grant", dut.last_grant, 2);
        chk("t1_idle", dut.state, 0);

        // NP blocked by buffer credit, CPL proceeds
        trn_tbuf_av = 4'b0100;
        load_pkt(1, 2'd0, 2, 64'h300);
        load_pkt(3, 2'd2, 2, 64'h400);
        clear_log();
        ticks(5);
        chk("t2_count", log_td.size(), 2);
        chk("t2_cpl_first", log_td[0], 64'h400);
        chk("t2_np_held", pk_pos[1], 0);
        trn_tbuf_av = 4'b0101;
        tick();
        tick();
        chk("t2_np_grant", last_rdy, 4'b1101);
        ticks(4);
        chk("t2_np_count", log_td.size(), 4);
        chk("t2_np_data", log_td[2], 64'h300);

        // Core stalls for 5 cycles mid-packet
        trn_tbuf_av = 4'b0111;
        load_pkt(0, 2'd1, 4, 64'hA5A5_0000_0000_0000);
        clear_log();
        ticks(3);
        trn_tdst_rdy_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_td_stable", trn_td, 64'hA5A5_0000_0000_0001);
            chk("t3_ch_stalled", last_rdy[0], 1);
        end
        trn_tdst_rdy_n = 1'b0;
        ticks(6);
        chk("t3_count", log_td.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("t3_order", log_td[k], 64'hA5A5_0000_0000_0000 + 64'(k));

        // Core discontinue on beat 2 of a 6-beat packet
        load_pkt(1, 2'd1, 6, 64'h600);
        clear_log();
        ticks(3);
        chk("t4_beat2", trn_td, 64'h601);
        trn_tdst_dsc_n = 1'b0;
        tick();
        trn_tdst_dsc_n = 1'b1;
        chk("t4_src_rdy", trn_tsrc_rdy_n, 1);
        chk("t4_drain", dut.state, 2);
        ticks(4);
        chk("t4_consumed", pk_pos[1], 6);
        chk("t4_nothing_out", log_td.size(), 2);
        chk("t4_idle", dut.state, 0);
`ifdef TRN_TX_ARB_STATS_EN
        chk("t4_dsc_cnt", dsc_cnt[1*8 +: 8], 1);
`endif

        // Link loss mid-packet
        load_pkt(2, 2'd1, 4, 64'h700);
        ticks(3);
        trn_lnk_up_n = 1'b1;
        #1;
        chk("t5_dsc_pulse", trn_tsrc_dsc_n, 0);
        chk("t5_dsc_beat", trn_tsrc_rdy_n, 0);
        load_pkt(0, 2'd1, 2, 64'h800);
        tick();
        chk("t5_dsc_end", trn_tsrc_dsc_n, 1);
        chk("t5_cleared", trn_tsrc_rdy_n, 1);
        chk("t5_drain", dut.state, 2);
        ticks(5);
        chk("t5_drained", pk_pos[2], 4);
        chk("t5_no_grant", pk_pos[0], 0);
        chk("t5_no_rdy", last_rdy, 4'hF);
        trn_lnk_up_n = 1'b0;
        clear_log();
        ticks(5);
        chk("t5_resume_count", log_td.size(), 2);
        chk("t5_resume_data", log_td[0], 64'h800);

        // Asynchronous reset in the middle of a transfer
        load_pkt(3, 2'd1, 4, 64'h900);
        ticks(3);
        trn_reset_n = 1'b0;
        #1;
        chk("t6_src_rdy", trn_tsrc_rdy_n, 1);
        chk("t6_td", trn_td, 0);
        chk("t6_ch_rdy", ch_tdst_rdy_n, 4'hF);
        chk("t6_sof_eof", {trn_tsof_n, trn_teof_n}, 2'b11);
        chk("t6_last_grant", dut.last_grant, 3);
        load_pkt(3, 2'd1, 2, 64'hB00);
        load_pkt(0, 2'd1, 2, 64'hA00);
        clear_log();
        @(negedge trn_clk);
        trn_reset_n = 1'b1;
        tick();
        tick();
        chk("t6_ch0_first", last_rdy, 4'b1110);
        ticks(6);
        chk("t6_first_data", log_td[0], 64'hA00);
        chk("t6_second_pkt", log_td[2], 64'hB00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trn_tx_arbiter.md
Name: trn_tx_arbiter

Overview:
- N-channel, packet-atomic round-robin arbiter that merges producer TLP streams onto the endpoint TRN transmit interface.
- Generalises the single-producer 64-bit TRN path: parametrised data width and channel count, honours trn_tbuf_av per TLP class, and handles destination discontinue and link loss.
- Sits between DMA/target engines and the PCIe endpoint core, in the trn_clk domain.

Parameters:
- NCH, 4, number of producer channels (2..8)
- DW, 64, TRN data width in bits (64 or 128)
- REMW, DW/8, width of the trn_trem_n byte-remainder field

Ports:
- trn_clk  in  1  TRN clock; all logic on its rising edge
- trn_reset_n  in  1  asynchronous active-low reset
- ch_td  in  NCH*DW  per-channel data; channel i in bits [i*DW +: DW]
- ch_trem_n  in  NCH*REMW  per-channel remainder
- ch_tsof_n  in  NCH  start of frame, active low
- ch_teof_n  in  NCH  end of frame, active low
- ch_tsrc_rdy_n  in  NCH  channel beat valid, active low
- ch_type  in  NCH*2  TLP class of the presented packet: 0 NP, 1 P, 2 CPL; valid with sof
- ch_tdst_rdy_n  out  NCH  beat accepted from channel, active low
- trn_td  out  DW  to core
- trn_trem_n  out  REMW  to core
- trn_tsof_n / trn_teof_n  out  1 each  to core
- trn_tsrc_rdy_n  out  1  to core
- trn_tsrc_dsc_n  out  1  source discontinue, to core
- trn_tdst_rdy_n  in  1  core ready, active low
- trn_tdst_dsc_n  in  1  core discontinue, active low
- trn_tbuf_av  in  4  core buffer availability; bit0 NP, bit1 P, bit2 CPL
- trn_lnk_up_n  in  1  link up, active low

Behaviour:
- Reset (async, trn_reset_n low): trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_tsrc_dsc_n=1, trn_td=0, trn_trem_n=0, ch_tdst_rdy_n all 1, last_grant=NCH-1 (channel 0 wins first), state IDLE.
- States: IDLE, XFER, DRAIN.
- IDLE: a channel is eligible when tsrc_rdy_n=0, tsof_n=0, trn_tbuf_av[ch_type]=1 and trn_lnk_up_n=0. Round-robin pick starts at last_grant+1 and wraps modulo NCH. The grant registers and the state moves to XFER next cycle, giving 1 cycle arbitration latency. Channels presenting non-sof beats in IDLE are ignored and stall.
- Output stage: one output register (out_v). The granted channel's ch_tdst_rdy_n=0 iff state is XFER and (out_v=0 or trn_tdst_rdy_n=0). An accepted beat loads the register the next cycle, so trn_tsrc_rdy_n follows 1 cycle after acceptance. No beat of a non-granted channel is ever accepted.
- A beat held on the TRN output (trn_tsrc_rdy_n=0 with trn_tdst_rdy_n=1) keeps all output fields stable.
- EOF: when the eof beat is accepted from the channel, set last_grant=grant and return to IDLE once that beat leaves the register. The next grant may be issued in the cycle the eof beat drains, giving back-to-back packets with zero bubble on TRN.
- trn_tdst_dsc_n=0 in XFER: clear out_v and drive trn_tsrc_rdy_n=1. If the channel's eof is not yet accepted, go to DRAIN; otherwise go to IDLE.
- DRAIN: hold the granted ch_tdst_rdy_n=0 and discard its beats until its eof beat, then go to IDLE.
- Link loss (trn_lnk_up_n=1) mid-packet: pulse trn_tsrc_dsc_n=0 for 1 cycle alongside the current beat, clear out_v, then go to DRAIN. No grants are issued while the link is down.
- trn_tbuf_av drop mid-packet: ignored; it gates packet start only.
- A single-beat packet (sof and eof together) is legal.

Optional Feature:
- Macro TRN_TX_ARB_STATS_EN.
- Defined: adds output port pkt_cnt (NCH*16) and dsc_cnt (NCH*8).
  - pkt_cnt is a per-channel 16-bit wrapping count of packets completed to the core.
  - dsc_cnt is a per-channel 8-bit count of discontinued packets. It saturates at 255.
  - Both reset to 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package trn_tx_pkg:
  - TLP class constants CLS_NP=0, CLS_P=1, CLS_CPL=2
  - state encoding IDLE/XFER/DRAIN
  - REMW derivation function
- Sub-module trn_rr_pick: combinational NCH-wide round-robin priority picker. Inputs are the request vector and last_grant; outputs are a one-hot grant plus its index.

Test Plan:
- Ch0 and ch2 each send one 3-beat P packet, tbuf_av=4'b0010, core always ready. Required: ch0 packet first, then ch2, zero idle cycle between eof and sof on TRN, last_grant=2.
- Ch1 requests NP while tbuf_av[0]=0 and ch3 requests CPL with tbuf_av[2]=1. Required: ch3 granted. Ch1 granted within 1 cycle after tbuf_av[0] rises.
- Core holds trn_tdst_rdy_n=1 for 5 cycles mid-packet (td=64'hA5A5_0000_0000_0001). Required: trn_td stable, the granted ch_tdst_rdy_n stays 1 after the register fills, and no beat is lost or duplicated.
- trn_tdst_dsc_n pulses on beat 2 of a 6-beat packet. Required: trn_tsrc_rdy_n=1 next cycle, the channel's remaining 4 beats are consumed with nothing output, then IDLE. With the stats macro defined, dsc_cnt[ch]=1.
- trn_lnk_up_n rises mid-packet. Required: 1-cycle trn_tsrc_dsc_n=0, then DRAIN, and no grants until the link is back up.
- Assert trn_reset_n low mid-XFER. Required: all outputs take their reset values immediately (async), and after release channel 0 is granted first.
